// File: rtl/gmii_mac.sv
// GMII receive-filter-loopback MAC: parses preamble/SFD/header,
// forwards accepted frames back out on TX with a fresh preamble.
module gmii_mac #(
  parameter logic [47:0] MAC_ADDR = 48'h386B1C1DF565,
  parameter logic [15:0] ETH_TYPE = 16'h0800,
  parameter logic [7:0]  SFD_BYTE = 8'hD5,
  parameter int unsigned PRE_MIN  = 7
) (
  input  logic       rx_clk,
  input  logic       reset,
  input  logic       sys_clk,
  output logic       gtx_clk,
  output logic [7:0] txd,
  output logic       txen,
  input  logic [7:0] rxd,
  input  logic       rxdv,
  input  logic       rxer
);

  localparam int          DL_LEN  = 22;
  localparam logic [3:0]  PRE_LIM = 4'(PRE_MIN);
  localparam logic [7:0]  PRE_B   = 8'h55;

  typedef enum logic [2:0] {
    RX_IDLE, RX_PRE, RX_HDR, RX_PAY, RX_DROP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_PRE, TX_DATA
  } tx_state_t;

  rx_state_t rx_state, rx_state_n;
  tx_state_t tx_state, tx_state_n;

  logic [3:0] pre_cnt, pre_cnt_n;
  logic [3:0] byte_cnt, byte_cnt_n;
  logic [7:0] hdr [0:12];
  logic       hdr_we;
  logic       tx_start, start_n;
  logic [2:0] tx_cnt, tx_cnt_n;
  logic       txen_n;
  logic [7:0] txd_n;

  logic [DL_LEN-1:0] dl_v;
  logic [7:0]        dl_d [0:DL_LEN-1];
  logic              din_v;

  logic [47:0] dest;
  logic        pass;
  logic        unused_ok;

  assign gtx_clk   = rx_clk;
  assign unused_ok = sys_clk;

  assign dest = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]};
  assign pass = (dest == MAC_ADDR || dest == 48'hFFFFFFFFFFFF)
             && ({hdr[12], rxd} == ETH_TYPE);

  assign din_v = rxdv
              && (rx_state == RX_HDR || rx_state == RX_PAY);

  always_comb begin
    rx_state_n = rx_state;
    pre_cnt_n  = pre_cnt;
    byte_cnt_n = byte_cnt;
    hdr_we     = 1'b0;
    start_n    = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rxdv && rxd == PRE_B) begin
          rx_state_n = RX_PRE;
          pre_cnt_n  = 4'd1;
        end
      end
      RX_PRE: begin
        if (!rxdv) begin
          rx_state_n = RX_IDLE;
        end else if (rxer) begin
          rx_state_n = RX_DROP;
        end else if (rxd == PRE_B) begin
          if (pre_cnt != 4'hF) pre_cnt_n = pre_cnt + 4'd1;
        end else if (rxd == SFD_BYTE && pre_cnt >= PRE_LIM) begin
          rx_state_n = RX_HDR;
          byte_cnt_n = 4'd0;
        end else begin
          rx_state_n = RX_DROP;
        end
      end
      RX_HDR: begin
        if (!rxdv) begin
          rx_state_n = RX_IDLE;
        end else if (rxer) begin
          rx_state_n = RX_DROP;
        end else begin
          hdr_we     = 1'b1;
          byte_cnt_n = byte_cnt + 4'd1;
          if (byte_cnt == 4'd13) begin
            if (pass) begin
              rx_state_n = RX_PAY;
              start_n    = 1'b1;
            end else begin
              rx_state_n = RX_DROP;
            end
          end
        end
      end
      RX_PAY, RX_DROP: begin
        if (!rxdv) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Output is registered, so the 22-stage line plus this
  // register gives the 22-edge loop latency.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    txen_n     = 1'b0;
    txd_n      = 8'h00;
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_start) begin
          tx_state_n = TX_PRE;
          tx_cnt_n   = 3'd1;
          txen_n     = 1'b1;
          txd_n      = PRE_B;
        end
      end
      TX_PRE: begin
        txen_n   = 1'b1;
        txd_n    = (tx_cnt == 3'd7) ? SFD_BYTE : PRE_B;
        tx_cnt_n = tx_cnt + 3'd1;
        if (tx_cnt == 3'd7) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        txen_n = dl_v[DL_LEN-1];
        txd_n  = dl_v[DL_LEN-1] ? dl_d[DL_LEN-1] : 8'h00;
        if (!dl_v[DL_LEN-1]) tx_state_n = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
      pre_cnt  <= '0;
      byte_cnt <= '0;
      tx_start <= 1'b0;
      tx_cnt   <= '0;
      txen     <= 1'b0;
      txd      <= '0;
      dl_v     <= '0;
      for (int i = 0; i < 13; i++) hdr[i] <= '0;
    end else begin
      rx_state <= rx_state_n;
      tx_state <= tx_state_n;
      pre_cnt  <= pre_cnt_n;
      byte_cnt <= byte_cnt_n;
      tx_start <= start_n;
      tx_cnt   <= tx_cnt_n;
      txen     <= txen_n;
      txd      <= txd_n;
      dl_v     <= {dl_v[DL_LEN-2:0], din_v};
      if (hdr_we && byte_cnt < 4'd13) hdr[byte_cnt] <= rxd;
    end
  end

  always_ff @(posedge rx_clk) begin
    dl_d[0] <= rxd;
    for (int i = 1; i < DL_LEN; i++) dl_d[i] <= dl_d[i-1];
  end

endmodule

// File: tb/tb_gmii_mac.sv
// Scoreboard bench for gmii_mac: driver queues expected TX bytes
// with their cycle, a negedge monitor pops and compares.
module tb_gmii_mac;

  logic       rx_clk = 1'b0;
  logic       sys_clk = 1'b0;
  logic       reset;
  logic       gtx_clk;
  logic [7:0] txd;
  logic       txen;
  logic [7:0] rxd;
  logic       rxdv;
  logic       rxer;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         cyc;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  gmii_mac dut (
    .rx_clk (rx_clk),
    .reset  (reset),
    .sys_clk(sys_clk),
    .gtx_clk(gtx_clk),
    .txd    (txd),
    .txen   (txen),
    .rxd    (rxd),
    .rxdv   (rxdv),
    .rxer   (rxer)
  );

  always #5 rx_clk = ~rx_clk;
  always #7 sys_clk = ~sys_clk;

  always @(posedge rx_clk) cyc <= cyc + 1;

  always @(negedge rx_clk) begin
    if (mon_en) begin
      checks++;
      if (txen === 1'b1) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_txen cyc=%0d txd=%02h", cyc, txd);
        end else begin
          if (q[0].cyc != cyc || q[0].d !== txd) begin
            errors++;
            $display("FAIL tx_byte cyc=%0d txd=%02h want cyc=%0d txd=%02h",
                     cyc, txd, q[0].cyc, q[0].d);
          end
          void'(q.pop_front());
        end
      end else begin
        if (txen !== 1'b0 || txd !== 8'h00) begin
          errors++;
          $display("FAIL idle_out cyc=%0d txen=%b txd=%02h want 0/00",
                   cyc, txen, txd);
        end
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          errors++;
          $display("FAIL missing_tx cyc=%0d txen=0 want txd=%02h",
                   cyc, q[0].d);
          void'(q.pop_front());
        end
      end
    end
  end

  function automatic bq_t mk(int pre_n, logic [7:0] sfd,
                             logic [47:0] dst, logic [15:0] typ);
    bq_t b;
    logic [7:0] pay [12] = '{8'h45, 8'h00, 8'h04, 8'h04, 8'h03, 8'h04,
                             8'h04, 8'h04, 8'h01, 8'h02, 8'h06, 8'h04};
    logic [47:0] src = 48'h0495E600EDAC;
    for (int i = 0; i < pre_n; i++) b.push_back(8'h55);
    b.push_back(sfd);
    for (int i = 5; i >= 0; i--) b.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(src[i*8 +: 8]);
    b.push_back(typ[15:8]);
    b.push_back(typ[7:0]);
    for (int i = 0; i < 12; i++) b.push_back(pay[i]);
    return b;
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(negedge rx_clk);
      rxd  = 8'h00;
      rxdv = 1'b0;
      rxer = 1'b0;
    end
  endtask

  // hs: index of dest byte 0; bytes from there on are echoed
  task automatic send(bq_t b, bit fwd, int hs, int er_idx, int rst_idx);
    int k0;
    int n;
    @(negedge rx_clk);
    k0 = cyc + 1;
    if (fwd) begin
      n = k0 + hs + 13;
      for (int j = 0; j < 8; j++)
        q.push_back('{n + 1 + j, (j == 7) ? 8'hD5 : 8'h55});
      for (int i = hs; i < b.size(); i++)
        q.push_back('{k0 + i + 22, b[i]});
    end
    for (int i = 0; i < b.size(); i++) begin
      if (i > 0) @(negedge rx_clk);
      rxd   = b[i];
      rxdv  = 1'b1;
      rxer  = (i == er_idx);
      reset = (i == rst_idx);
      if (i == rst_idx)
        while (q.size() != 0 && q[$].cyc > cyc) void'(q.pop_back());
    end
    idle(30);
  endtask

  localparam logic [47:0] MAC = 48'h386B1C1DF565;
  localparam logic [47:0] BC  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] BAD = 48'h386B1C1DF566;

  initial begin
    bq_t f;
    reset = 1'b1;
    rxd   = 8'h01;
    rxdv  = 1'b0;
    rxer  = 1'b0;
    repeat (3) @(negedge rx_clk);
    mon_en = 1;
    repeat (2) @(negedge rx_clk);
    reset = 1'b0;
    repeat (3) @(negedge rx_clk);

    repeat (24) begin
      @(negedge rx_clk);
      rxd = 8'h55;
    end
    @(negedge rx_clk);
    rxd = 8'h11;
    idle(5);

    send(mk(8, 8'hD5, MAC, 16'h0800), 1, 9, -1, -1);
    send(mk(8, 8'hD5, BC, 16'h0800), 1, 9, -1, -1);
    send(mk(8, 8'hD5, BAD, 16'h0800), 0, 9, -1, -1);
    send(mk(8, 8'hD5, MAC, 16'h86DD), 0, 9, -1, -1);
    send(mk(8, 8'hD5, MAC, 16'h0800), 1, 9, -1, -1);

    send(mk(6, 8'hD5, MAC, 16'h0800), 0, 7, -1, -1);
    send(mk(8, 8'hD5, MAC, 16'h0800), 1, 9, -1, -1);
    send(mk(8, 8'h5D, MAC, 16'h0800), 0, 9, -1, -1);
    send(mk(8, 8'hD5, MAC, 16'h0800), 1, 9, -1, -1);
    send(mk(8, 8'hD5, MAC, 16'h0800), 0, 9, 12, -1);
    send(mk(8, 8'hD5, MAC, 16'h0800), 1, 9, -1, -1);

    f = mk(8, 8'hD5, MAC, 16'h0800);
    while (f.size() > 19) void'(f.pop_back());
    send(f, 0, 9, -1, -1);
    send(mk(8, 8'hD5, BC, 16'h0800), 1, 9, -1, -1);

    send(mk(8, 8'hD5, MAC, 16'h0800), 1, 9, -1, 30);
    send(mk(8, 8'hD5, MAC, 16'h0800), 1, 9, -1, -1);

    idle(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d want 0", q.size());
    end
    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
